// File: rtl/reg_transfer_seq.sv
// Block-transfer sequencer between an 8x32 register file and a pair of valid/ready streams.
// DUMP streams selected registers out in ascending index order; LOAD writes incoming beats into them.
module reg_transfer_seq #(
   parameter int DW   = 32,
   parameter int AW   = 3,
   parameter int NREG = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dir,
   input  logic [NREG-1:0] mask,
   output logic            busy,
   output logic            done,
   output logic [AW:0]     count,
   output logic [AW-1:0]   rf_ra,
   input  logic [DW-1:0]   rf_rd,
   output logic [AW-1:0]   rf_wa,
   output logic [DW-1:0]   rf_wd,
   output logic            rf_we,
   output logic [DW-1:0]   out_data,
   output logic [AW-1:0]   out_tag,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic [DW-1:0]   in_data,
   input  logic            in_valid,
   output logic            in_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DUMP = 2'd1,
      S_LOAD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q;
   logic [NREG-1:0] pend_q;
   logic            dir_q;
   logic [AW:0]     count_q;
   logic            busy_q;
   logic            done_q;
   logic [DW-1:0]   out_data_q;
   logic [AW-1:0]   out_tag_q;
   logic            out_valid_q;

   logic [AW-1:0]   idx;
   logic [NREG-1:0] pend_clr_d;
   logic            pend_any;

   function automatic logic [AW-1:0] lowest_set(input logic [NREG-1:0] v);
      logic [AW-1:0] r;
      r = {AW{1'b0}};
      for (int i = NREG - 1; i >= 0; i--) begin
         if (v[i]) r = AW'(i);
      end
      return r;
   endfunction

   function automatic logic [NREG-1:0] bit_sel(input logic [AW-1:0] i);
      return {{(NREG-1){1'b0}}, 1'b1} << i;
   endfunction

   // Next register to service and the pending set with it retired.
   always_comb begin
      idx        = lowest_set(pend_q);
      pend_clr_d = pend_q & ~bit_sel(idx);
      pend_any   = (pend_q != {NREG{1'b0}});
   end

   // Register-file and load-stream strobes; writes and beats are suppressed while reset is asserted.
   always_comb begin
      rf_ra    = {AW{1'b0}};
      rf_wa    = {AW{1'b0}};
      rf_wd    = {DW{1'b0}};
      rf_we    = 1'b0;
      in_ready = 1'b0;
      if ((state_q == S_DUMP) && !dir_q) begin
         rf_ra = idx;
      end else begin
         rf_ra = {AW{1'b0}};
      end
      if (state_q == S_LOAD) begin
         rf_wa = idx;
         rf_wd = in_data;
      end else begin
         rf_wa = {AW{1'b0}};
         rf_wd = {DW{1'b0}};
      end
      if (rst && (state_q == S_LOAD) && dir_q && pend_any) begin
         in_ready = 1'b1;
         rf_we    = in_valid;
      end else begin
         in_ready = 1'b0;
         rf_we    = 1'b0;
      end
   end

   // Sequencer FSM with registered status and dump-stream outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pend_q      <= {NREG{1'b0}};
         dir_q       <= 1'b0;
         count_q     <= {(AW+1){1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= {DW{1'b0}};
         out_tag_q   <= {AW{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pend_q  <= mask;
                  dir_q   <= dir;
                  count_q <= {(AW+1){1'b0}};
                  if (mask == {NREG{1'b0}}) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= dir ? S_LOAD : S_DUMP;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_DUMP: begin
               if (out_valid_q && out_ready) begin
                  count_q <= count_q + {{AW{1'b0}}, 1'b1};
               end
               // Output slot is free or being drained this cycle.
               if (!out_valid_q || out_ready) begin
                  if (pend_any) begin
                     out_data_q  <= rf_rd;
                     out_tag_q   <= idx;
                     out_valid_q <= 1'b1;
                     pend_q      <= pend_clr_d;
                  end else begin
                     out_valid_q <= 1'b0;
                     state_q     <= S_DONE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (rf_we) begin
                  pend_q  <= pend_clr_d;
                  count_q <= count_q + {{AW{1'b0}}, 1'b1};
                  if (pend_clr_d == {NREG{1'b0}}) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               pend_q      <= {NREG{1'b0}};
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/reg_transfer_seq.md
Name: reg_transfer_seq

Overview:
- Initiator-side block-transfer sequencer for the 8 x 32-bit register file (2 async read ports, 1 sync write port).
- DUMP drives one read-address port and streams the masked registers out over a valid/ready interface.
- LOAD accepts a valid/ready input stream and drives the write port, one register per beat.
- Serves load/store-multiple and context save/restore; transfers run in ascending register index.

Parameters:
DW, 32, data width; equals register file word width
AW, 3, register address width
NREG, 8, number of registers; equals 2**AW; also the mask width

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  command strobe; sampled only in IDLE
dir  input  1  0 = DUMP (registers to stream), 1 = LOAD (stream to registers)
mask  input  NREG  register select; bit i set = transfer register i
busy  output  1  high in DUMP and LOAD
done  output  1  one-cycle completion pulse
count  output  AW+1  registers transferred by the current or last command
rf_ra  output  AW  register file read address
rf_rd  input  DW  register file read data (combinational in rf_ra)
rf_wa  output  AW  register file write address
rf_wd  output  DW  register file write data
rf_we  output  1  register file write enable
out_data  output  DW  dump stream data (registered)
out_tag  output  AW  register index of out_data (registered)
out_valid  output  1  dump stream valid
out_ready  input  1  dump stream ready
in_data  input  DW  load stream data
in_valid  input  1  load stream valid
in_ready  output  1  load stream ready

Behaviour:
- States: IDLE, DUMP, LOAD, DONE.
- Internal registers: pend (NREG bits) and dir_q.
- idx = index of the lowest set bit of pend; idx = 0 when pend == 0.
- Reset: synchronous. rst == 0 at a rising edge forces:
  - state = IDLE, pend = 0, count = 0;
  - out_valid = 0, out_data = 0, out_tag = 0.
  - Reset aborts any command; no done pulse follows.
  - rf_we and in_ready are gated by rst, so no register write or stream beat occurs on a reset edge.
- IDLE:
  - busy = 0, in_ready = 0, rf_we = 0.
  - start == 1 latches pend <= mask, dir_q <= dir, count <= 0.
  - If mask == 0, next state is DONE. Otherwise next state is DUMP when dir == 0, LOAD when dir == 1.
- DUMP:
  - rf_ra = idx, driven combinationally.
  - Load condition, per cycle: (!out_valid || out_ready).
  - Load condition true and pend != 0: out_data <= rf_rd, out_tag <= idx, out_valid <= 1, clear bit idx of pend.
  - Load condition true and pend == 0: out_valid <= 0, next state DONE.
  - Sustains one register per cycle when out_ready is held high.
  - First out_valid is asserted on the 2nd edge after the start edge.
  - While out_valid && !out_ready, out_data and out_tag hold stable.
  - count increments on every out_valid && out_ready.
- LOAD:
  - in_ready = (pend != 0).
  - rf_wa = idx, rf_wd = in_data, rf_we = in_valid && in_ready, all combinational; the write commits at the register file's edge.
  - On each handshake: clear bit idx of pend, count++.
  - When the handshake clears the last pend bit, next state is DONE.
  - in_valid low inserts idle cycles with rf_we = 0.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
- start is ignored in DUMP, LOAD and DONE.
- mask/dir changes after acceptance have no effect.
- count saturates by construction at NREG (8 fits in AW+1 bits). It holds after done until the next accepted start.
- rf_ra = 0 outside DUMP; rf_wa = 0 and rf_wd = 0 outside LOAD.

Test Plan:
1. Reset: hold rst = 0 for 2 edges with start = 1 -> busy = done = out_valid = in_ready = rf_we = 0, count = 0; no transfer begins.
2. Load mask = 8'b1000_1010, dir = 1, in_valid = 1, in_data = 32'h11111111 / 32'h33333333 / 32'h77777777 -> rf_we high 3 consecutive cycles, rf_wa = 1, 3, 7; done pulses the following cycle; count = 3; registers 1, 3, 7 read back those values.
3. Dump mask = 8'hFF, out_ready = 1, r[i] = i * 32'h11111111 -> out_valid high 8 consecutive cycles starting at edge 2, out_tag = 0..7, out_data = 32'h00000000 .. 32'h77777777; done one cycle after the last beat; count = 8.
4. Backpressure: dump mask = 8'h05 with out_ready = 0 for 3 cycles -> out_data = r0, out_tag = 0 held stable; then ready -> r2, tag 2; count = 2.
5. mask = 0 -> done on the cycle after the start edge, no out_valid and no rf_we, count = 0. A start pulsed during the done cycle is ignored.
6. Reset mid-LOAD (mask = 8'h0E) after the first beat, with in_valid still high -> only r1 written, rf_we = 0 on the reset edge, no done, state IDLE.
